// File: rtl/cmp_share_arbiter_if.sv
// Requester-side bundle for the shared comparator arbiter: request/operand
// inputs and the registered grant, done and result outputs.
interface cmp_share_arbiter_if #(
    parameter int WIDTH = 3
);
    // valid/ready: a requester holds req and its operands stable until it sees
    // its gnt bit; the operands are captured on that edge and done follows one
    // cycle later.
    logic [3:0]         req;
    logic [4*WIDTH-1:0] a_bus;
    logic [4*WIDTH-1:0] b_bus;
    logic [3:0]         gnt;
    logic [3:0]         done;
    logic               lesser;
    logic               greater;
    logic               equal;
    logic               busy;

    modport master (
        output req, a_bus, b_bus,
        input  gnt, done, lesser, greater, equal, busy
    );

    modport slave (
        input  req, a_bus, b_bus,
        output gnt, done, lesser, greater, equal, busy
    );
endinterface

// File: rtl/cmp_share_arbiter.sv
// Round-robin arbiter sharing one registered unsigned magnitude comparator
// among four requesters; grant captures operands, done returns the result.
module cmp_share_arbiter #(
    parameter int WIDTH = 3,
    parameter int NREQ  = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    cmp_share_arbiter_if.slave bus,
    output logic               state_dbg
);
    typedef enum logic {IDLE, CMP} state_t;

    state_t                    state;
    logic [$clog2(NREQ)-1:0]   ptr;
    logic [$clog2(NREQ)-1:0]   id;
    logic [WIDTH-1:0]          op_a;
    logic [WIDTH-1:0]          op_b;

    logic [$clog2(NREQ)-1:0]   win;
    logic [$clog2(NREQ)-1:0]   idx;
    logic                      found;
    logic [WIDTH-1:0]          win_a;
    logic [WIDTH-1:0]          win_b;

    // Search starts at ptr and walks upward modulo NREQ; first request wins.
    always_comb begin
        win   = ptr;
        idx   = '0;
        found = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            idx = ptr + ($clog2(NREQ))'(k);
            if (!found && bus.req[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
        win_a = bus.a_bus[win*WIDTH +: WIDTH];
        win_b = bus.b_bus[win*WIDTH +: WIDTH];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            ptr         <= '0;
            id          <= '0;
            op_a        <= '0;
            op_b        <= '0;
            bus.gnt     <= '0;
            bus.done    <= '0;
            bus.lesser  <= 1'b0;
            bus.greater <= 1'b0;
            bus.equal   <= 1'b0;
            bus.busy    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    bus.done <= '0;
                    if (found) begin
                        bus.gnt  <= 4'b0001 << win;
                        id       <= win;
                        op_a     <= win_a;
                        op_b     <= win_b;
                        ptr      <= win + 1'b1;
                        bus.busy <= 1'b1;
                        state    <= CMP;
                    end else begin
                        bus.gnt <= '0;
                    end
                end
                CMP: begin
                    // req is deliberately not looked at here; the winner is fixed.
                    bus.lesser  <= (op_a < op_b);
                    bus.greater <= (op_a > op_b);
                    bus.equal   <= (op_a == op_b);
                    bus.done    <= 4'b0001 << id;
                    bus.gnt     <= '0;
                    bus.busy    <= 1'b0;
                    state       <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign state_dbg = (state == CMP);
endmodule
